// File: rtl/bram_stream_reader.sv
// Streams a (start address, length) run of BRAM words out as AXI-Stream.
// A small output FIFO plus a credit count let the stream stall without ever losing a word.
module bram_stream_reader #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  bram_rden,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned CRED_W = CNT_W + 1;
   localparam int unsigned IDX_W  = LEN_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  rden_q, rden_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  rd_last_q, rd_last_d;
   logic                  cap_q, cap_last_q;
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic                  mem_last [FIFO_DEPTH];

   logic                  fifo_nonempty;
   logic                  pop;
   logic [CRED_W-1:0]     credits;
   logic                  can_issue;

   // credits = buffered words + reads still in the two-stage BRAM pipeline
   assign fifo_nonempty = (count_q != CNT_W'(0));
   assign pop           = fifo_nonempty && m_axis_tready;
   assign credits       = CRED_W'(count_q) + CRED_W'(cap_q) + CRED_W'(rden_q);
   assign can_issue     = (credits < CRED_W'(FIFO_DEPTH));

   always_comb begin
      state_d   = state_q;
      rden_d    = 1'b0;
      addr_d    = addr_q;
      idx_d     = idx_q;
      len_d     = len_q;
      rd_last_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               rden_d    = 1'b1;
               addr_d    = cmd_addr;
               len_d     = cmd_len;
               idx_d     = IDX_W'(1);
               rd_last_d = (cmd_len == LEN_WIDTH'(0));
               state_d   = (cmd_len == LEN_WIDTH'(0)) ? DRAIN : ISSUE;
            end
         end
         ISSUE: begin
            if (can_issue) begin
               rden_d    = 1'b1;
               addr_d    = addr_q + ADDR_WIDTH'(1);
               idx_d     = idx_q + IDX_W'(1);
               rd_last_d = (idx_q == IDX_W'(len_q));
               if (idx_q == IDX_W'(len_q)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && mem_last[rd_ptr_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rden_q     <= 1'b0;
         addr_q     <= '0;
         idx_q      <= '0;
         len_q      <= '0;
         rd_last_q  <= 1'b0;
         cap_q      <= 1'b0;
         cap_last_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         rden_q     <= rden_d;
         addr_q     <= addr_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         rd_last_q  <= rd_last_d;
         cap_q      <= rden_q;
         cap_last_q <= rd_last_q;
         if (cap_q) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q    <= count_q + CNT_W'(cap_q) - CNT_W'(pop);
      end
   end

   // storage needs no reset: count_q gates every read of it
   always_ff @(posedge clk) begin
      if (cap_q) begin
         mem_data[wr_ptr_q] <= bram_dout;
         mem_last[wr_ptr_q] <= cap_last_q;
      end
   end

   assign cmd_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign bram_rden     = rden_q;
   assign bram_addr     = addr_q;
   assign m_axis_tvalid = fifo_nonempty;
   assign m_axis_tdata  = mem_data[rd_ptr_q];
   assign m_axis_tlast  = fifo_nonempty && mem_last[rd_ptr_q];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: command table, busy hold-off,
// reset mid-burst and a 4-bit-address wrap instance.
module tb_bram_stream_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, rden, tvalid, tready, tlast, busy;
   logic [15:0] cmd_addr, cmd_len, bram_addr;
   logic [31:0] dout, tdata;

   logic        w_cmd_valid, w_cmd_ready, w_rden, w_tvalid, w_tready, w_tlast, w_busy;
   logic [3:0]  w_cmd_addr, w_addr;
   logic [15:0] w_cmd_len;
   logic [31:0] w_dout, w_tdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bram_stream_reader dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .bram_rden(rden), .bram_addr(bram_addr),
      .bram_dout(dout), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
      .m_axis_tready(tready), .m_axis_tlast(tlast), .busy(busy)
   );

   bram_stream_reader #(.ADDR_WIDTH(4)) dut_w (
      .clk(clk), .rst(rst), .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready),
      .cmd_addr(w_cmd_addr), .cmd_len(w_cmd_len), .bram_rden(w_rden), .bram_addr(w_addr),
      .bram_dout(w_dout), .m_axis_tdata(w_tdata), .m_axis_tvalid(w_tvalid),
      .m_axis_tready(w_tready), .m_axis_tlast(w_tlast), .busy(w_busy)
   );

   function automatic logic [31:0] ram_f(input logic [15:0] a);
      return {a ^ 16'h5A5A, ~a};
   endfunction

   // one-cycle-latency BRAM models
   always @(posedge clk) if (rden)   dout   <= ram_f(bram_addr);
   always @(posedge clk) if (w_rden) w_dout <= ram_f({12'h000, w_addr});

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // call just after the command handshake edge; returns at the negedge where cmd_ready is back
   task automatic collect(input logic [15:0] a, input logic [15:0] len, input bit bp,
                          output int f_rden, output int f_valid, output int done);
      int cyc = 1, beats = 0, issued = 0;
      bit stalled = 1'b0;
      logic [31:0] sd = '0;
      logic sl = 1'b0;
      f_rden  = -1;
      f_valid = -1;
      while (beats <= int'(len) && cyc < 400) begin
         tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         chk("busy_ready", {62'd0, busy, cmd_ready}, 64'd2);
         if (rden) begin
            if (f_rden < 0) f_rden = cyc;
            chk("rden_addr", 64'(bram_addr), 64'(16'(a + 16'(issued))));
            issued++;
         end
         if (tvalid) begin
            if (f_valid < 0) f_valid = cyc;
            if (stalled) begin
               chk("stall_data", 64'(tdata), 64'(sd));
               chk("stall_last", 64'(tlast), 64'(sl));
            end
            if (tready) begin
               chk("beat_data", 64'(tdata), 64'(ram_f(16'(a + 16'(beats)))));
               chk("beat_last", 64'(tlast), 64'(beats == int'(len)));
               beats++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               sd = tdata;
               sl = tlast;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 400) chk("timeout", 64'd0, 64'd1);
      chk("issued", 64'(issued), 64'(int'(len) + 1));
      @(negedge clk);
      chk("ready_after", 64'(cmd_ready), 64'd1);
      done = cyc;
   endtask

   task automatic run_cmd(input logic [15:0] a, input logic [15:0] len, input bit bp,
                          output int f_rden, output int f_valid, output int done);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = len;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      collect(a, len, bp, f_rden, f_valid, done);
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [15:0] len;
      bit          bp;
      int          exp_rden;
      int          exp_valid;
      int          exp_done;
   } vec_t;

   initial begin
      vec_t vecs[5];
      int fr, fv, dn;
      int wexp[4];
      int wn, wb;

      vecs[0] = '{16'h0005, 16'd0,  1'b0, 1, 3, 4};
      vecs[1] = '{16'h0010, 16'd7,  1'b0, 1, 3, 11};
      vecs[2] = '{16'h0100, 16'd15, 1'b1, 1, 3, -1};
      vecs[3] = '{16'hFFFE, 16'd3,  1'b0, 1, 3, 7};
      vecs[4] = '{16'h0020, 16'd5,  1'b1, 1, 3, -1};
      wexp = '{14, 15, 0, 1};

      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; tready = 1'b0;
      w_cmd_valid = 1'b0; w_cmd_addr = '0; w_cmd_len = '0; w_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_rden", 64'(rden), 64'd0);
      chk("rst_addr", 64'(bram_addr), 64'd0);
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk("rst_tlast", 64'(tlast), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_w_ready", 64'(w_cmd_ready), 64'd1);

      foreach (vecs[i]) begin
         run_cmd(vecs[i].addr, vecs[i].len, vecs[i].bp, fr, fv, dn);
         chk($sformatf("v%0d_first_rden", i), 64'(fr), 64'(vecs[i].exp_rden));
         chk($sformatf("v%0d_first_valid", i), 64'(fv), 64'(vecs[i].exp_valid));
         if (vecs[i].exp_done >= 0)
            chk($sformatf("v%0d_done", i), 64'(dn), 64'(vecs[i].exp_done));
      end

      // busy: second command held valid during the first burst
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = 16'h0200; cmd_len = 16'd3;
      @(posedge clk); #1;
      cmd_addr = 16'h0300; cmd_len = 16'd2;
      collect(16'h0200, 16'd3, 1'b1, fr, fv, dn);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      collect(16'h0300, 16'd2, 1'b0, fr, fv, dn);
      chk("busy_second_done", 64'(dn), 64'd6);

      // reset mid-burst with the stream stalled
      tready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = 16'h0400; cmd_len = 16'd7;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_tvalid", 64'(tvalid), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst", {60'd0, tvalid, rden, cmd_ready, busy}, 64'b0010);
      tready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_quiet", {62'd0, tvalid, rden}, 64'd0);
      end
      run_cmd(16'h0040, 16'd2, 1'b0, fr, fv, dn);
      chk("post_rst_done", 64'(dn), 64'd6);

      // 4-bit address wrap: 14,15,0,1
      @(negedge clk);
      w_cmd_valid = 1'b1; w_cmd_addr = 4'd14; w_cmd_len = 16'd3;
      @(posedge clk); #1;
      w_cmd_valid = 1'b0;
      wn = 0; wb = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (w_rden) begin
            if (wn < 4) chk("wrap_addr", 64'(w_addr), 64'(wexp[wn]));
            wn++;
         end
         if (w_tvalid) begin
            if (wb < 4) begin
               chk("wrap_data", 64'(w_tdata), 64'(ram_f(16'(wexp[wb]))));
               chk("wrap_last", 64'(w_tlast), 64'(wb == 3));
            end
            wb++;
         end
      end
      chk("wrap_reads", 64'(wn), 64'd4);
      chk("wrap_beats", 64'(wb), 64'd4);
      chk("wrap_idle", 64'(w_cmd_ready), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
